// File: rtl/odu_multi_gen_fifo_if.sv
// Handshake/data bundle between the multi-channel ODU word generator FIFO and its consumer.
// slave = generator side, master = the block driving enables and pops.
interface odu_multi_gen_fifo_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 384,
  parameter int ADDR_WIDTH = 3
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW   = DATA_WIDTH + 3 + CH_W;

  logic [NUM_CH-1:0]     enable_chid;
  logic [NUM_CH-1:0]     type_chid;
  logic                  fifo_read_enable;
  logic [DATA_WIDTH-1:0] data_chid;
  logic                  data_valid_chid;
  logic [CH_W-1:0]       ch_id_out;
  logic [FW-1:0]         fifo_data_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [ADDR_WIDTH:0]   fifo_level;

  modport master (
    output enable_chid, type_chid, fifo_read_enable,
    input  data_chid, data_valid_chid, ch_id_out, fifo_data_out,
           fifo_empty, fifo_full, fifo_level
  );

  modport slave (
    input  enable_chid, type_chid, fifo_read_enable,
    output data_chid, data_valid_chid, ch_id_out, fifo_data_out,
           fifo_empty, fifo_full, fifo_level
  );
endinterface

// File: rtl/odu_multi_gen_fifo.sv
// Round-robin multi-channel ODU pattern generator feeding a shared FIFO.
// Optional status counters (words_written, stall_cycles) are built when ODU_GEN_STATUS_EN is defined.
module odu_multi_gen_fifo #(
  parameter int NUM_CH        = 4,
  parameter int DATA_WIDTH    = 384,
  parameter int ADDR_WIDTH    = 3,
  parameter int ROWS          = 4,
  parameter int WORDS_PER_ROW = 80
) (
  input logic                 clk,
  input logic                 rst,
  odu_multi_gen_fifo_if.slave bus
`ifdef ODU_GEN_STATUS_EN
  ,
  output logic [31:0]         words_written,
  output logic [31:0]         stall_cycles
`endif
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FW     = DATA_WIDTH + 3 + CH_W;
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int REP    = DATA_WIDTH / 32;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WORD_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  // Reset asserts immediately but releases only after two clean clock edges.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_reg <= '0;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_reg[1];

  logic [CH_W-1:0]       last_grant_reg;
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [CH_W-1:0]       ch_reg;
  logic                  row_start_reg;
  logic                  frame_start_reg;

  logic [FW-1:0]         mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   level_reg;
  logic [FW-1:0]         dout_reg;

  logic [31:0]           seq_reg   [NUM_CH];
  logic [ROW_W-1:0]      row_reg   [NUM_CH];
  logic [WORD_W-1:0]     word_reg  [NUM_CH];
  logic [7:0]            frame_reg [NUM_CH];

  // The in-flight word is counted so the FIFO can never be asked to take a word it has no room for.
  logic [ADDR_WIDTH+1:0] occupancy;
  logic                  can_grant;
  logic                  grant_any;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       cand;

  assign occupancy = {1'b0, level_reg} + (ADDR_WIDTH+2)'(valid_reg);
  assign can_grant = occupancy < (ADDR_WIDTH+2)'(DEPTH);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (can_grant) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = CH_W'((int'(last_grant_reg) + k) % NUM_CH);
        if (!grant_any && bus.enable_chid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic grant_ch;
      assign grant_ch = grant_any && (grant_idx == CH_W'(gi));

      // A disabled channel restarts at the top of a frame; seq and frame keep counting across gaps.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          seq_reg[gi]   <= '0;
          row_reg[gi]   <= '0;
          word_reg[gi]  <= '0;
          frame_reg[gi] <= '0;
        end else if (!bus.enable_chid[gi]) begin
          row_reg[gi]  <= '0;
          word_reg[gi] <= '0;
        end else if (grant_ch) begin
          seq_reg[gi] <= seq_reg[gi] + 32'd1;
          if (word_reg[gi] == WORD_W'(WORDS_PER_ROW - 1)) begin
            word_reg[gi] <= '0;
            if (row_reg[gi] == ROW_W'(ROWS - 1)) begin
              row_reg[gi]   <= '0;
              frame_reg[gi] <= frame_reg[gi] + 8'd1;
            end else begin
              row_reg[gi] <= row_reg[gi] + ROW_W'(1);
            end
          end else begin
            word_reg[gi] <= word_reg[gi] + WORD_W'(1);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg  <= CH_W'(NUM_CH - 1);
      valid_reg       <= 1'b0;
      data_reg        <= '0;
      ch_reg          <= '0;
      row_start_reg   <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      valid_reg <= grant_any;
      if (grant_any) begin
        last_grant_reg  <= grant_idx;
        data_reg        <= {REP{seq_reg[grant_idx]}} ^ {DATA_WIDTH{bus.type_chid[grant_idx]}};
        ch_reg          <= grant_idx;
        row_start_reg   <= (word_reg[grant_idx] == '0);
        frame_start_reg <= (word_reg[grant_idx] == '0) && (row_reg[grant_idx] == '0);
      end
    end
  end

  logic push;
  logic pop;

  assign push = valid_reg;
  assign pop  = bus.fifo_read_enable && (level_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {1'b1, frame_start_reg, row_start_reg, ch_reg, data_reg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      dout_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_WIDTH'(1);
        dout_reg   <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (ADDR_WIDTH+1)'(1);
        2'b01:   level_reg <= level_reg - (ADDR_WIDTH+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

`ifdef ODU_GEN_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_written <= '0;
      stall_cycles  <= '0;
    end else begin
      if (push) begin
        words_written <= words_written + 32'd1;
      end
      if ((|bus.enable_chid) && !can_grant) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

  assign bus.data_chid       = data_reg;
  assign bus.data_valid_chid = valid_reg;
  assign bus.ch_id_out       = ch_reg;
  assign bus.fifo_data_out   = dout_reg;
  assign bus.fifo_level      = level_reg;
  assign bus.fifo_empty      = (level_reg == '0);
  assign bus.fifo_full       = (level_reg == (ADDR_WIDTH+1)'(DEPTH));
endmodule

// File: doc/odu_multi_gen_fifo.md
ODU_MULTI_GEN_FIFO -- requirements
Module: odu_multi_gen_fifo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of generator channels (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 384, payload width, multiple of 32.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, FIFO depth DEPTH = 2**ADDR_WIDTH.
REQ-004 SHALL have parameter ROWS, default 4, rows per frame; parameter WORDS_PER_ROW, default 80, words per row.
REQ-005 SHALL define CH_W = max(1, clog2(NUM_CH)) and FW = DATA_WIDTH+3+CH_W.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 enable_chid  in  NUM_CH  per-channel generate enable.
REQ-009 type_chid  in  NUM_CH  per-channel pattern select (0 increment, 1 inverted).
REQ-010 fifo_read_enable  in  1  pop request.
REQ-011 data_chid  out  DATA_WIDTH  registered generator word.
REQ-012 data_valid_chid  out  1  data_chid valid, one-cycle pulse per word.
REQ-013 ch_id_out  out  CH_W  channel of data_chid.
REQ-014 fifo_data_out  out  FW  {valid, frame_start, row_start, ch_id, data}, MSB first.
REQ-015 fifo_empty, fifo_full  out  1 each; fifo_level  out  ADDR_WIDTH+1  occupancy 0..DEPTH.

Function
REQ-016 Arbiter SHALL grant at most one enabled channel per cycle, round-robin from (last_grant+1) mod NUM_CH, lowest index first after pointer.
REQ-017 Grant SHALL occur only when fifo_level + data_valid_chid < DEPTH (counts in-flight word); otherwise no grant, pointer holds.
REQ-018 Grant in cycle t SHALL produce data_valid_chid=1 in t+1, written to FIFO at end of t+1.
REQ-019 Per channel: 32-bit seq counter, row counter, word counter, 8-bit frame counter; seq, word, row, frame advance only on that channel's grant.
REQ-020 data_chid SHALL be seq replicated DATA_WIDTH/32 times, bitwise inverted when type_chid[ch]=1 (sampled at grant).
REQ-021 row_start = (word==0); frame_start = (word==0 && row==0), both from pre-increment position of granted word.
REQ-022 word wraps WORDS_PER_ROW-1 -> 0 incrementing row; row wraps ROWS-1 -> 0 incrementing frame; frame and seq wrap modulo 2**8 / 2**32.
REQ-023 Enable falling on a channel SHALL clear its row/word counters (next word is frame_start); seq and frame counters hold.
REQ-024 FIFO pop when fifo_read_enable && !fifo_empty; fifo_data_out registered, updated one cycle after pop, holds otherwise.
REQ-025 Read while empty SHALL be ignored; simultaneous push and pop SHALL keep fifo_level unchanged; pointers wrap modulo DEPTH.
REQ-026 No word SHALL ever be dropped or overwritten; fifo_full never coincides with a write.
REQ-027 With no enabled channels, no grants; data_valid_chid=0.

Reset
REQ-028 rst=0 SHALL asynchronously clear all counters, pointers, arbiter pointer (last_grant = NUM_CH-1), data_chid, ch_id_out, data_valid_chid, fifo_data_out to 0; fifo_empty=1, fifo_full=0, fifo_level=0.
REQ-029 Reset mid-frame SHALL discard FIFO contents; first word after release is seq 0, frame_start=1.
REQ-030 Reset release SHALL be synchronised to clk internally (two-flop) before deasserting.

Configuration
REQ-031 Macro ODU_GEN_STATUS_EN defined: adds output words_written (32 bits, count of FIFO writes, wraps) and stall_cycles (32 bits, cycles with an enabled channel but no grant due to REQ-017); both reset to 0.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification (NUM_CH=4, ADDR_WIDTH=3, ROWS=4, WORDS_PER_ROW=4 unless stated)
REQ-033 Enable ch0 only, type 0, read always -> data_chid seq 0,1,2..., frame_start on seq 0,16,32, row_start every 4th word, frame counter 1 after 16 words.
REQ-034 Enable all 4, read always -> ch_id_out sequence 0,1,2,3,0,...; each channel seq increments independently.
REQ-035 Enable ch2, no reads -> exactly 8 writes, fifo_full=1, fifo_level=8, no grant until a pop; first pop returns seq 0 with valid=1, frame_start=1.
REQ-036 ch1 type 1, ch1 enable dropped after 6 words then re-raised -> next word inverted seq 6 with frame_start=1, row_start=1.
REQ-037 rst=0 pulse mid-frame with FIFO at level 5 -> level 0, fifo_empty=1 immediately; next word seq 0.
REQ-038 ODU_GEN_STATUS_EN defined, scenario REQ-035 held 20 cycles -> words_written=8, stall_cycles counts every blocked cycle.
